// File: rtl/exception_pkg.sv
// rtl/exception_pkg.sv - shared state/cause types and ALU flag positions for exception_ctrl
package exception_pkg;

  // Controller sequencing: entry flush, vector redirect, then wait for ERET.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    HANDLER  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_PC   = 2'd1,
    CAUSE_OVF  = 2'd2,
    CAUSE_DIVZ = 2'd3
  } cause_e;

  localparam int ALU_OVF_BIT  = 0;
  localparam int ALU_DIVZ_BIT = 1;

endpackage

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - pipeline-facing signal bundle of exception_ctrl
// master: pipeline side (drives fault inputs, eret, enable writes)
// slave : exception_ctrl (drives flush/redirect/epc/cause/status)
// exc_count is present only when EXC_COUNT_EN is defined.
interface exception_ctrl_if #(
  parameter int PC_W = 32
);
  logic            instr_valid;
  logic            pc_exception;
  logic [7:0]      alu_status;
  logic [PC_W-1:0] fault_pc;
  logic            eret;
  logic            exc_en_wr;
  logic            exc_en_din;
  logic            exc_flush;
  logic            pc_redirect;
  logic [PC_W-1:0] redirect_addr;
  logic [PC_W-1:0] epc;
  logic [1:0]      cause;
  logic            in_handler;
  logic            missed;
`ifdef EXC_COUNT_EN
  logic [15:0]     exc_count;
`endif

  modport master (
    output instr_valid, pc_exception, alu_status, fault_pc, eret, exc_en_wr, exc_en_din,
    input  exc_flush, pc_redirect, redirect_addr, epc, cause, in_handler, missed
`ifdef EXC_COUNT_EN
    , exc_count
`endif
  );

  modport slave (
    input  instr_valid, pc_exception, alu_status, fault_pc, eret, exc_en_wr, exc_en_din,
    output exc_flush, pc_redirect, redirect_addr, epc, cause, in_handler, missed
`ifdef EXC_COUNT_EN
    , exc_count
`endif
  );

endinterface

// File: rtl/exc_cause_enc.sv
// rtl/exc_cause_enc.sv - priority encoder from fault sources to exception cause
// pc_exception_i : PC fault (highest priority)
// alu_status_i   : ALU flags, overflow then divide-by-zero; upper bits unused
// cause_o        : encoded cause, CAUSE_NONE when no source is active
module exc_cause_enc
  import exception_pkg::*;
(
  input  logic       pc_exception_i,
  input  logic [7:0] alu_status_i,
  output cause_e     cause_o
);

  always_comb begin
    cause_o = CAUSE_NONE;
    if (pc_exception_i) begin
      cause_o = CAUSE_PC;
    end else if (alu_status_i[ALU_OVF_BIT]) begin
      cause_o = CAUSE_OVF;
    end else if (alu_status_i[ALU_DIVZ_BIT]) begin
      cause_o = CAUSE_DIVZ;
    end
  end

  logic [5:0] unused_alu_flags;
  assign unused_alu_flags = alu_status_i[7:2];

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception entry/return sequencer: EPC/cause capture, flush, redirect
// clk, rst_n : clock, asynchronous active-low reset
// bus        : exception_ctrl_if slave (fault inputs in; flush, redirect, epc, cause,
//              in_handler, missed out; exc_count out when EXC_COUNT_EN is defined)
// Optional: EXC_COUNT_EN adds a saturating 16-bit taken-exception counter.
module exception_ctrl
  import exception_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] VECTOR_ADDR  = PC_W'(32'h0000_0080),
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  exception_ctrl_if.slave   bus
);

  // Counter is loaded with the last index at capture, so exc_flush spans FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e          state_q;
  logic [3:0]      flush_cnt_q;
  logic            exc_en_q;
  logic [PC_W-1:0] epc_q;
  logic [1:0]      cause_q;
  logic            in_handler_q;
  logic            missed_q;
  logic            exc_flush_q;
  logic            pc_redirect_q;
  logic [PC_W-1:0] redirect_addr_q;
`ifdef EXC_COUNT_EN
  logic [15:0]     exc_count_q;
`endif

  cause_e enc_cause;
  logic   exc_req;

  exc_cause_enc u_cause_enc (
    .pc_exception_i (bus.pc_exception),
    .alu_status_i   (bus.alu_status),
    .cause_o        (enc_cause)
  );

  assign exc_req = bus.instr_valid & exc_en_q & (enc_cause != CAUSE_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      flush_cnt_q     <= '0;
      exc_en_q        <= 1'b1;
      epc_q           <= '0;
      cause_q         <= CAUSE_NONE;
      in_handler_q    <= 1'b0;
      missed_q        <= 1'b0;
      exc_flush_q     <= 1'b0;
      pc_redirect_q   <= 1'b0;
      redirect_addr_q <= '0;
`ifdef EXC_COUNT_EN
      exc_count_q     <= '0;
`endif
    end else begin
      // Redirect is a one-cycle strobe; the address bus idles at zero.
      pc_redirect_q   <= 1'b0;
      redirect_addr_q <= '0;

      if (bus.exc_en_wr) begin
        exc_en_q <= bus.exc_en_din;
      end

      case (state_q)
        IDLE: begin
          if (exc_req) begin
            state_q      <= FLUSH;
            epc_q        <= bus.fault_pc;
            cause_q      <= enc_cause;
            in_handler_q <= 1'b1;
            missed_q     <= 1'b0;
            exc_flush_q  <= 1'b1;
            flush_cnt_q  <= FLUSH_LAST;
`ifdef EXC_COUNT_EN
            if (exc_count_q != 16'hFFFF) begin
              exc_count_q <= exc_count_q + 16'd1;
            end
`endif
          end
        end
        FLUSH: begin
          if (exc_req) begin
            missed_q <= 1'b1;
          end
          if (flush_cnt_q == 4'd0) begin
            exc_flush_q     <= 1'b0;
            pc_redirect_q   <= 1'b1;
            redirect_addr_q <= VECTOR_ADDR;
            state_q         <= REDIRECT;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        REDIRECT: begin
          if (exc_req) begin
            missed_q <= 1'b1;
          end
          state_q <= HANDLER;
        end
        HANDLER: begin
          // A fault that arrives alongside ERET is still lost: the return takes priority.
          if (exc_req) begin
            missed_q <= 1'b1;
          end
          if (bus.eret) begin
            pc_redirect_q   <= 1'b1;
            redirect_addr_q <= epc_q;
            in_handler_q    <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.exc_flush     = exc_flush_q;
  assign bus.pc_redirect   = pc_redirect_q;
  assign bus.redirect_addr = redirect_addr_q;
  assign bus.epc           = epc_q;
  assign bus.cause         = cause_q;
  assign bus.in_handler    = in_handler_q;
  assign bus.missed        = missed_q;
`ifdef EXC_COUNT_EN
  assign bus.exc_count     = exc_count_q;
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed and randomized self-checking bench for exception_ctrl
module tb_exception_ctrl;
  localparam int          PC_W = 32;
  localparam logic [31:0] VEC  = 32'h0000_0080;
  localparam int          FC   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  exception_ctrl_if #(.PC_W(PC_W)) bus ();

  exception_ctrl #(
    .PC_W         (PC_W),
    .VECTOR_ADDR  (VEC),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an entry is a point in time; the flush window, vector redirect and
  // handler residency are derived from the number of edges elapsed since that point.
  int          m_cyc = 0;
  int          m_entry = 0;
  bit          m_in = 0;
  bit          m_en = 1;
  bit          m_missed = 0;
  logic [31:0] m_epc = '0;
  logic [1:0]  m_cause = '0;
  int          m_cnt = 0;
  bit          e_flush = 0;
  bit          e_redir = 0;
  logic [31:0] e_addr = '0;

  task automatic model_reset();
    m_in = 0; m_en = 1; m_missed = 0; m_epc = '0; m_cause = '0; m_cnt = 0;
    e_flush = 0; e_redir = 0; e_addr = '0;
  endtask

  task automatic model_step();
    bit req;
    bit ret;
    int p;
    logic [1:0] c;
    c   = bus.pc_exception ? 2'd1 : bus.alu_status[0] ? 2'd2 : bus.alu_status[1] ? 2'd3 : 2'd0;
    req = bus.instr_valid && m_en && (c != 2'd0);
    ret = 0;
    if (!m_in) begin
      if (req) begin
        m_in = 1; m_entry = m_cyc + 1; m_epc = bus.fault_pc; m_cause = c; m_missed = 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      p = m_cyc - m_entry;
      if (p > FC && bus.eret) begin
        m_in = 0; ret = 1;
      end
      if (req) m_missed = 1;
    end
    if (bus.exc_en_wr) m_en = bus.exc_en_din;
    m_cyc++;
    e_flush = 0; e_redir = 0; e_addr = '0;
    if (ret) begin
      e_redir = 1; e_addr = m_epc;
    end else if (m_in) begin
      p = m_cyc - m_entry;
      e_flush = (p < FC);
      e_redir = (p == FC);
      e_addr  = e_redir ? VEC : '0;
    end
  endtask

  task automatic clr_inputs();
    bus.instr_valid = 0; bus.pc_exception = 0; bus.alu_status = '0; bus.fault_pc = '0;
    bus.eret = 0; bus.exc_en_wr = 0; bus.exc_en_din = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    #2 rst_n = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.exc_flush, bus.pc_redirect, bus.in_handler, bus.missed} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000",
                         {bus.exc_flush, bus.pc_redirect, bus.in_handler, bus.missed});
    end
    checks++;
    if ({bus.redirect_addr, bus.epc, bus.cause} !== 66'd0) begin
      errors++; $display("FAIL reset_regs got addr=%h epc=%h cause=%0d want 0",
                         bus.redirect_addr, bus.epc, bus.cause);
    end
    rst_n = 1;
    bus.eret = 1;
    tick();
    bus.eret = 0;
    checks++;
    if (bus.pc_redirect !== 1'b0 || bus.in_handler !== 1'b0) begin
      errors++; $display("FAIL idle_eret got redirect=%b in_handler=%b want 0 0",
                         bus.pc_redirect, bus.in_handler);
    end
  endtask

  task automatic test_ovf_entry();
    bus.fault_pc = 32'h104; bus.alu_status = 8'h01; bus.instr_valid = 1;
    tick();
    clr_inputs();
    checks++;
    if (bus.cause !== 2'd2 || bus.epc !== 32'h104 || bus.in_handler !== 1'b1) begin
      errors++; $display("FAIL ovf_capture got cause=%0d epc=%h exl=%b want 2 104 1",
                         bus.cause, bus.epc, bus.in_handler);
    end
    for (int i = 0; i < FC; i++) begin
      checks++;
      if (bus.exc_flush !== 1'b1 || bus.pc_redirect !== 1'b0) begin
        errors++; $display("FAIL ovf_flush%0d got flush=%b redir=%b want 1 0",
                           i, bus.exc_flush, bus.pc_redirect);
      end
      tick();
    end
    checks++;
    if (bus.exc_flush !== 1'b0 || bus.pc_redirect !== 1'b1 || bus.redirect_addr !== VEC) begin
      errors++; $display("FAIL ovf_vector got flush=%b redir=%b addr=%h want 0 1 %h",
                         bus.exc_flush, bus.pc_redirect, bus.redirect_addr, VEC);
    end
    tick();
    checks++;
    if (bus.pc_redirect !== 1'b0 || bus.redirect_addr !== 32'h0) begin
      errors++; $display("FAIL ovf_strobe got redir=%b addr=%h want 0 0",
                         bus.pc_redirect, bus.redirect_addr);
    end
    tick();
    bus.eret = 1;
    tick();
    bus.eret = 0;
    checks++;
    if (bus.pc_redirect !== 1'b1 || bus.redirect_addr !== 32'h104 || bus.in_handler !== 1'b0 ||
        bus.cause !== 2'd2) begin
      errors++; $display("FAIL ovf_eret got redir=%b addr=%h exl=%b cause=%0d want 1 104 0 2",
                         bus.pc_redirect, bus.redirect_addr, bus.in_handler, bus.cause);
    end
    tick();
  endtask

  task automatic test_priority_missed();
    bus.fault_pc = 32'h200; bus.pc_exception = 1; bus.alu_status = 8'h03; bus.instr_valid = 1;
    tick();
    clr_inputs();
    checks++;
    if (bus.cause !== 2'd1 || bus.missed !== 1'b0) begin
      errors++; $display("FAIL prio_cause got cause=%0d missed=%b want 1 0", bus.cause, bus.missed);
    end
    repeat (FC + 1) tick();
    bus.fault_pc = 32'h300; bus.alu_status = 8'h01; bus.instr_valid = 1;
    tick();
    clr_inputs();
    checks++;
    if (bus.missed !== 1'b1 || bus.epc !== 32'h200 || bus.cause !== 2'd1) begin
      errors++; $display("FAIL handler_missed got missed=%b epc=%h cause=%0d want 1 200 1",
                         bus.missed, bus.epc, bus.cause);
    end
    bus.eret = 1;
    tick();
    bus.eret = 0;
    tick();
    checks++;
    if (bus.missed !== 1'b1 || bus.in_handler !== 1'b0) begin
      errors++; $display("FAIL missed_sticky got missed=%b exl=%b want 1 0",
                         bus.missed, bus.in_handler);
    end
  endtask

  task automatic test_disable();
    int bad;
    do_reset();
    bus.exc_en_wr = 1; bus.exc_en_din = 0;
    tick();
    clr_inputs();
    bus.fault_pc = 32'h400; bus.alu_status = 8'h02; bus.instr_valid = 1;
    tick();
    clr_inputs();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.exc_flush !== 1'b0 || bus.pc_redirect !== 1'b0 || bus.cause !== 2'd0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL disabled_entry got %0d active cycles want 0", bad);
    end
    bus.exc_en_wr = 1; bus.exc_en_din = 1;
    tick();
    clr_inputs();
  endtask

  task automatic test_reset_mid_flush();
    int bad;
    bus.fault_pc = 32'h500; bus.alu_status = 8'h01; bus.instr_valid = 1;
    tick();
    clr_inputs();
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if ({bus.exc_flush, bus.pc_redirect, bus.in_handler, bus.cause, bus.epc} !== 37'd0) begin
      errors++; $display("FAIL async_reset got flush=%b exl=%b cause=%0d epc=%h want 0",
                         bus.exc_flush, bus.in_handler, bus.cause, bus.epc);
    end
    @(posedge clk);
    #1 rst_n = 1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.pc_redirect !== 1'b0 || bus.exc_flush !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_no_redirect got %0d active cycles want 0", bad);
    end
  endtask

`ifdef EXC_COUNT_EN
  task automatic test_count();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      bus.fault_pc = 32'h600 + 32'(4 * n); bus.alu_status = 8'h02; bus.instr_valid = 1;
      tick();
      clr_inputs();
      repeat (FC + 2) tick();
      bus.eret = 1;
      tick();
      bus.eret = 0;
      tick();
    end
    checks++;
    if (bus.exc_count !== 16'd3) begin
      errors++; $display("FAIL count_three got %0d want 3", bus.exc_count);
    end
    force dut.exc_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.exc_count_q;
    m_cnt = 65535;
    bus.alu_status = 8'h01; bus.instr_valid = 1;
    tick();
    clr_inputs();
    checks++;
    if (bus.exc_count !== 16'hFFFF) begin
      errors++; $display("FAIL count_saturate got %h want ffff", bus.exc_count);
    end
    repeat (FC + 2) tick();
    bus.eret = 1;
    tick();
    clr_inputs();
  endtask
`endif

  task automatic test_random();
    int bad_flush, bad_redir, bad_addr, bad_epc, bad_cause, bad_exl, bad_missed;
    bad_flush = 0; bad_redir = 0; bad_addr = 0; bad_epc = 0;
    bad_cause = 0; bad_exl = 0; bad_missed = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.instr_valid  = ($urandom_range(0, 2) == 0);
      bus.pc_exception = ($urandom_range(0, 5) == 0);
      bus.alu_status   = 8'($urandom) & {6'h3F, 2'($urandom_range(0, 3))};
      bus.fault_pc     = $urandom & 32'hFFFF_FFFC;
      bus.eret         = ($urandom_range(0, 3) == 0);
      bus.exc_en_wr    = ($urandom_range(0, 15) == 0);
      bus.exc_en_din   = ($urandom_range(0, 2) != 0);
      tick();
      if (bus.exc_flush     !== e_flush)  bad_flush++;
      if (bus.pc_redirect   !== e_redir)  bad_redir++;
      if (bus.redirect_addr !== e_addr)   bad_addr++;
      if (bus.epc           !== m_epc)    bad_epc++;
      if (bus.cause         !== m_cause)  bad_cause++;
      if (bus.in_handler    !== m_in)     bad_exl++;
      if (bus.missed        !== m_missed) bad_missed++;
    end
    clr_inputs();
    checks++;
    if (bad_flush != 0) begin errors++; $display("FAIL rand_flush got %0d bad cycles want 0", bad_flush); end
    checks++;
    if (bad_redir != 0) begin errors++; $display("FAIL rand_redirect got %0d bad cycles want 0", bad_redir); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL rand_addr got %0d bad cycles want 0", bad_addr); end
    checks++;
    if (bad_epc != 0) begin errors++; $display("FAIL rand_epc got %0d bad cycles want 0", bad_epc); end
    checks++;
    if (bad_cause != 0) begin errors++; $display("FAIL rand_cause got %0d bad cycles want 0", bad_cause); end
    checks++;
    if (bad_exl != 0) begin errors++; $display("FAIL rand_in_handler got %0d bad cycles want 0", bad_exl); end
    checks++;
    if (bad_missed != 0) begin errors++; $display("FAIL rand_missed got %0d bad cycles want 0", bad_missed); end
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_ovf_entry();
    test_priority_missed();
    test_disable();
    test_reset_mid_flush();
`ifdef EXC_COUNT_EN
    test_count();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
